// File: rtl/fpu_align_sched.sv
// Round-robin scheduler sharing one mantissa aligner among NREQ requesters; orders operands by exponent.
// Latency: accept edge -> result register loaded on the following edge; one result per cycle at full rate.
// Backpressure: s2 holds on !res_ready, s1 holds behind a full s2, and req_ready goes all-zero when both are full.
module fpu_align_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_exp_a,
    input  logic [8*NREQ-1:0]    req_exp_b,
    input  logic [24*NREQ-1:0]   req_mant_a,
    input  logic [24*NREQ-1:0]   req_mant_b,
    output logic [23:0]          align_mant_in,
    output logic [7:0]           align_exp_diff,
    input  logic [23:0]          align_mant_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [7:0]           res_exp,
    output logic [23:0]          res_mant_big,
    output logic [23:0]          res_mant_small,
    output logic                 res_swap,
    output logic                 res_far
);
    logic [IDW-1:0] ptr;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand_idx;

    logic           s1_valid;
    logic [IDW-1:0] s1_id;
    logic [7:0]     s1_exp;
    logic [23:0]    s1_big;
    logic [23:0]    s1_small;
    logic [7:0]     s1_diff;
    logic           s1_swap;
    logic           s1_far;
    logic           s2_valid;

    logic           s1_advance;
    logic           s1_can_accept;
    logic           hs;

    logic [7:0]     sel_exp_a;
    logic [7:0]     sel_exp_b;
    logic [23:0]    sel_mant_a;
    logic [23:0]    sel_mant_b;
    logic           b_bigger;
    logic [7:0]     nxt_diff;

    // Search upward starting just past the last granted index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_idx = IDW'((int'(ptr) + i) % NREQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign s1_advance    = s1_valid && (!s2_valid || res_ready);
    assign s1_can_accept = !s1_valid || s1_advance;
    assign hs            = rst_n && gnt_found && s1_can_accept;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_exp_a  = req_exp_a[8*gnt_idx +: 8];
    assign sel_exp_b  = req_exp_b[8*gnt_idx +: 8];
    assign sel_mant_a = req_mant_a[24*gnt_idx +: 24];
    assign sel_mant_b = req_mant_b[24*gnt_idx +: 24];

    // Equal exponents keep A as the big operand.
    assign b_bigger = sel_exp_b > sel_exp_a;
    assign nxt_diff = b_bigger ? (sel_exp_b - sel_exp_a) : (sel_exp_a - sel_exp_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_exp   <= '0;
            s1_big   <= '0;
            s1_small <= '0;
            s1_diff  <= '0;
            s1_swap  <= 1'b0;
            s1_far   <= 1'b0;
        end else if (hs) begin
            ptr      <= gnt_idx;
            s1_valid <= 1'b1;
            s1_id    <= gnt_idx;
            s1_swap  <= b_bigger;
            s1_exp   <= b_bigger ? sel_exp_b : sel_exp_a;
            s1_big   <= b_bigger ? sel_mant_b : sel_mant_a;
            s1_small <= b_bigger ? sel_mant_a : sel_mant_b;
            s1_diff  <= nxt_diff;
            s1_far   <= (nxt_diff >= 8'd24);
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    assign align_mant_in  = s1_valid ? s1_small : '0;
    assign align_exp_diff = s1_valid ? s1_diff  : '0;

    // Far shifts are zeroed here so the aligner may truncate its shift amount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            res_id         <= '0;
            res_exp        <= '0;
            res_mant_big   <= '0;
            res_mant_small <= '0;
            res_swap       <= 1'b0;
            res_far        <= 1'b0;
        end else if (s1_advance) begin
            s2_valid       <= 1'b1;
            res_id         <= s1_id;
            res_exp        <= s1_exp;
            res_mant_big   <= s1_big;
            res_mant_small <= s1_far ? '0 : align_mant_out;
            res_swap       <= s1_swap;
            res_far        <= s1_far;
        end else if (res_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign res_valid = s2_valid;

endmodule

// File: tb/tb_fpu_align_sched.sv
// Directed and random bench for fpu_align_sched with a queue-based reference model.
module tb_fpu_align_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_exp_a;
    logic [8*NREQ-1:0]   req_exp_b;
    logic [24*NREQ-1:0]  req_mant_a;
    logic [24*NREQ-1:0]  req_mant_b;
    logic [23:0]         align_mant_in;
    logic [7:0]          align_exp_diff;
    logic [23:0]         align_mant_out;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [7:0]          res_exp;
    logic [23:0]         res_mant_big;
    logic [23:0]         res_mant_small;
    logic                res_swap;
    logic                res_far;

    fpu_align_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_exp_a(req_exp_a), .req_exp_b(req_exp_b),
        .req_mant_a(req_mant_a), .req_mant_b(req_mant_b),
        .align_mant_in(align_mant_in), .align_exp_diff(align_exp_diff),
        .align_mant_out(align_mant_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_exp(res_exp), .res_mant_big(res_mant_big), .res_mant_small(res_mant_small),
        .res_swap(res_swap), .res_far(res_far)
    );

    // Cheap aligner with a 5-bit shifter: wrong for shifts >= 32, which the DUT must mask.
    assign align_mant_out = align_mant_in >> align_exp_diff[4:0];

    logic        vld [NREQ];
    logic [7:0]  ea  [NREQ];
    logic [7:0]  eb  [NREQ];
    logic [23:0] ma  [NREQ];
    logic [23:0] mb  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = vld[i];
            req_exp_a[8*i +: 8]   = ea[i];
            req_exp_b[8*i +: 8]   = eb[i];
            req_mant_a[24*i +: 24] = ma[i];
            req_mant_b[24*i +: 24] = mb[i];
        end
    end

    typedef struct {
        int          id;
        int          acc;
        logic [7:0]  exp;
        logic [23:0] big;
        logic [23:0] sml;
        logic        swap;
        logic        far;
    } item_t;

    item_t q[$];
    int    acc_ids[$];
    int    pop_ids[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    pops = 0;
    int    mptr = NREQ - 1;
    int    mode = 0;
    int    issue_left = 0;
    int    lr_id;
    logic [7:0]  lr_exp;
    logic [23:0] lr_big;
    logic [23:0] lr_small;
    logic        lr_swap;
    logic        lr_far;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_grant();
        for (int i = 1; i <= NREQ; i++) begin
            if (vld[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Reference result: larger exponent wins, ties keep A, shifts of 24 or more vanish.
    function automatic item_t mk(input int id, input int acc);
        item_t it;
        int a;
        int b;
        int d;
        a = int'(ea[id]);
        b = int'(eb[id]);
        it.id  = id;
        it.acc = acc;
        if (b > a) begin
            it.swap = 1'b1; it.exp = eb[id]; it.big = mb[id]; it.sml = ma[id]; d = b - a;
        end else begin
            it.swap = 1'b0; it.exp = ea[id]; it.big = ma[id]; it.sml = mb[id]; d = a - b;
        end
        it.far = (d >= 24);
        it.sml = it.far ? 24'd0 : (it.sml >> d);
        return it;
    endfunction

    task automatic new_ops(input int i);
        ea[i] = 8'($urandom);
        case ($urandom_range(3))
            0:       eb[i] = ea[i];
            1:       eb[i] = ea[i] + 8'($urandom_range(30));
            2:       eb[i] = ea[i] - 8'($urandom_range(30));
            default: eb[i] = 8'($urandom);
        endcase
        ma[i]  = {1'b1, 23'($urandom)};
        mb[i]  = {1'b1, 23'($urandom)};
        vld[i] = 1'b1;
    endtask

    task automatic refill(input int i);
        case (mode)
            0: vld[i] = 1'b0;
            1: new_ops(i);
            2: begin
                if (issue_left > 0) begin
                    issue_left--;
                    new_ops(i);
                end else begin
                    vld[i] = 1'b0;
                end
            end
            default: begin
                new_ops(i);
                vld[i] = ($urandom_range(3) != 0);
            end
        endcase
    endtask

    // One clock: check outputs at the falling edge, update the model, then advance.
    task automatic tick();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] hs;
        int g;
        bit ev;
        @(negedge clk);
        g  = exp_grant();
        er = '0;
        if (g >= 0 && (q.size() < 2 || res_ready)) er = NREQ'(1) << g;
        chk("req_ready", 64'(req_ready), 64'(er));
        ev = (q.size() > 0) && (q[0].acc + 2 <= cyc);
        chk("res_valid", 64'(res_valid), 64'(ev));
        if (ev) begin
            chk("res_id",         64'(res_id),         64'(q[0].id));
            chk("res_exp",        64'(res_exp),        64'(q[0].exp));
            chk("res_mant_big",   64'(res_mant_big),   64'(q[0].big));
            chk("res_mant_small", 64'(res_mant_small), 64'(q[0].sml));
            chk("res_swap",       64'(res_swap),       64'(q[0].swap));
            chk("res_far",        64'(res_far),        64'(q[0].far));
        end
        if (q.size() == 0) begin
            chk("idle_align_in",   64'(align_mant_in),  64'(0));
            chk("idle_align_diff", 64'(align_exp_diff), 64'(0));
        end
        hs = req_valid & req_ready;
        if (ev && res_ready) begin
            lr_id = int'(res_id); lr_exp = res_exp; lr_big = res_mant_big;
            lr_small = res_mant_small; lr_swap = res_swap; lr_far = res_far;
            pop_ids.push_back(int'(res_id));
            void'(q.pop_front());
            pops++;
        end
        g = -1;
        for (int i = 0; i < NREQ; i++) if (hs[i] && g < 0) g = i;
        if (g >= 0) begin
            q.push_back(mk(g, cyc));
            acc_ids.push_back(g);
            mptr = g;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (hs[i]) refill(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_res_valid",  64'(res_valid),      64'(0));
        chk("rst_req_ready",  64'(req_ready),      64'(0));
        chk("rst_res_exp",    64'(res_exp),        64'(0));
        chk("rst_res_small",  64'(res_mant_small), 64'(0));
        chk("rst_align_in",   64'(align_mant_in),  64'(0));
        chk("rst_align_diff", 64'(align_exp_diff), 64'(0));
        q.delete();
        mptr = NREQ - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [23:0] x, input logic [23:0] y);
        mode = 0;
        ea[id] = a; eb[id] = b; ma[id] = x; mb[id] = y; vld[id] = 1'b1;
        repeat (4) tick();
    endtask

    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
    int bp_exp [5] = '{0, 1, 2, 3, 0};
    int p0;

    initial begin
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b0; ea[i] = '0; eb[i] = '0; ma[i] = '0; mb[i] = '0;
        end
        vld[0] = 1'b1;
        #1;
        do_reset();
        vld[0] = 1'b0;

        // Single request, two-cycle latency.
        mode = 0;
        p0 = pops;
        ea[2] = 8'd130; eb[2] = 8'd127; ma[2] = 24'hC00000; mb[2] = 24'h800000; vld[2] = 1'b1;
        tick(); tick();
        chk("lat_no_early", 64'(pops - p0), 64'(0));
        tick();
        chk("lat_result", 64'(pops - p0), 64'(1));
        tick();
        chk("s_id",    64'(lr_id),    64'(2));
        chk("s_exp",   64'(lr_exp),   64'(130));
        chk("s_swap",  64'(lr_swap),  64'(0));
        chk("s_big",   64'(lr_big),   64'(24'hC00000));
        chk("s_small", 64'(lr_small), 64'(24'h100000));
        chk("s_far",   64'(lr_far),   64'(0));

        single(1, 8'd100, 8'd140, 24'hFFFFFF, 24'h800000);
        chk("swap_swap",  64'(lr_swap),  64'(1));
        chk("swap_exp",   64'(lr_exp),   64'(140));
        chk("swap_far",   64'(lr_far),   64'(1));
        chk("swap_small", 64'(lr_small), 64'(0));

        ea[3] = 8'd127; eb[3] = 8'd127; ma[3] = 24'hA00000; mb[3] = 24'h9ABCDE; vld[3] = 1'b1;
        tick();
        chk("eq_align_diff", 64'(align_exp_diff), 64'(0));
        chk("eq_align_in",   64'(align_mant_in),  64'(24'h9ABCDE));
        repeat (3) tick();
        chk("eq_swap",  64'(lr_swap),  64'(0));
        chk("eq_small", 64'(lr_small), 64'(24'h9ABCDE));

        single(0, 8'd150, 8'd127, 24'h800000, 24'hFFFFFF);
        chk("d23_far",   64'(lr_far),   64'(0));
        chk("d23_small", 64'(lr_small), 64'(1));
        single(1, 8'd151, 8'd127, 24'h800000, 24'hFFFFFF);
        chk("d24_far",   64'(lr_far),   64'(1));
        chk("d24_small", 64'(lr_small), 64'(0));
        single(2, 8'd255, 8'd0, 24'h800000, 24'hFFFFFF);
        chk("d255_far",   64'(lr_far),   64'(1));
        chk("d255_small", 64'(lr_small), 64'(0));

        // Round robin with every requester continuously valid.
        do_reset();
        mode = 1;
        acc_ids.delete(); pop_ids.delete();
        p0 = pops;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        repeat (12) tick();
        chk("rr_throughput", 64'(pops - p0), 64'(10));
        for (int i = 0; i < 6; i++) begin
            chk("rr_grant", 64'(acc_ids[i]), 64'(rr_exp[i]));
            chk("rr_res_id", 64'(pop_ids[i]), 64'(rr_exp[i]));
        end
        mode = 0;
        repeat (8) tick();
        chk("rr_drained", 64'(q.size()), 64'(0));

        // Five requests with a three-cycle consumer stall after the first result.
        do_reset();
        mode = 2; issue_left = 1;
        acc_ids.delete(); pop_ids.delete();
        p0 = pops;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        repeat (3) tick();
        chk("bp_first", 64'(pops - p0), 64'(1));
        res_ready = 1'b0;
        repeat (3) tick();
        chk("bp_stall_ready", 64'(req_ready), 64'(0));
        chk("bp_stall_valid", 64'(res_valid), 64'(1));
        res_ready = 1'b1;
        repeat (8) tick();
        chk("bp_count", 64'(pops - p0), 64'(5));
        for (int i = 0; i < 5; i++) chk("bp_order", 64'(pop_ids[i]), 64'(bp_exp[i]));
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Reset with both stages full.
        mode = 1;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        res_ready = 1'b0;
        repeat (3) tick();
        chk("mid_full", 64'(res_valid), 64'(1));
        do_reset();
        res_ready = 1'b1;
        acc_ids.delete();
        tick();
        chk("mid_first_grant", 64'(acc_ids.size() > 0 ? acc_ids[0] : -1), 64'(0));
        mode = 0;
        repeat (10) tick();
        chk("mid_drained", 64'(q.size()), 64'(0));

        // Random traffic with random consumer stalls.
        mode = 3;
        for (int n = 0; n < 400; n++) begin
            res_ready = ($urandom_range(3) != 0);
            tick();
            for (int i = 0; i < NREQ; i++) if (!vld[i] && $urandom_range(2) == 0) new_ops(i);
        end
        mode = 0;
        res_ready = 1'b1;
        repeat (20) tick();
        chk("rand_drained", 64'(q.size()), 64'(0));
        chk("rand_idle_valid", 64'(res_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_align_sched.md
Name: fpu_align_sched

Overview:
- Shares one combinational mantissa-alignment unit (24-bit mantissa, 8-bit exponent-difference shift) between NREQ requesters, e.g. the adder lanes of a TPU processing element.
- Round-robin arbitration picks one operand pair per cycle. The block orders the pair by exponent, drives the shared alignment unit, and returns the aligned result with a requester tag.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit is high.
- req_exp_a  in  8*NREQ  operand A biased exponent; requester i uses slice [8i+7:8i].
- req_exp_b  in  8*NREQ  operand B biased exponent.
- req_mant_a  in  24*NREQ  operand A mantissa with hidden bit; requester i uses slice [24i+23:24i].
- req_mant_b  in  24*NREQ  operand B mantissa with hidden bit.
- align_mant_in  out  24  to shared aligner: mantissa to shift right.
- align_exp_diff  out  8  to shared aligner: shift amount.
- align_mant_out  in  24  from shared aligner: shifted mantissa, combinational from the two outputs above.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_id  out  IDW  requester index that produced the result.
- res_exp  out  8  larger exponent.
- res_mant_big  out  24  mantissa of the larger-exponent operand, unshifted.
- res_mant_small  out  24  mantissa of the smaller-exponent operand, aligned.
- res_swap  out  1  1 when B had the larger exponent.
- res_far  out  1  1 when exponent difference >= 24.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid=0, s2_valid=0, all res_* = 0.
  - req_ready=0 while in reset.
  - RR pointer = NREQ-1, so requester 0 has highest priority first.
  - align_mant_in=0, align_exp_diff=0.
- Arbitration (combinational):
  - Among the asserted req_valid bits, grant the first index searching upward from pointer+1 mod NREQ.
  - req_ready[g]=1 only when s1_can_accept. s1_can_accept = !s1_valid || s1_advance.
  - req_ready must not depend on req_valid of the granted requester beyond the grant selection.
- Pointer update: pointer <= g only on an accepted handshake (req_valid[g] && req_ready[g]). No handshake leaves the pointer unchanged.
- Stage 1 register, loaded on handshake:
  - id=g.
  - If exp_b > exp_a: swap=1, big = B, small = A, diff = exp_b - exp_a.
  - Otherwise, including equal exponents: swap=0, big = A, small = B, diff = exp_a - exp_b.
  - Diff is computed at 8 bits unsigned and cannot go negative.
  - far = (diff >= 24).
- Aligner drive: align_mant_in = s1 small mantissa; align_exp_diff = s1 diff. Both held stable while s1_valid, including during a stall. Both are 0 when s1 is empty.
- Stage 2 register, loaded when s1_advance = s1_valid && (!s2_valid || res_ready):
  - res_mant_small = far ? 0 : align_mant_out. The block forces zero itself and does not rely on the aligner for diff >= 24.
  - res_exp, res_mant_big, res_swap, res_far and res_id copied from stage 1.
  - s2_valid is set.
- s2_valid clears when res_valid && res_ready with no new s1_advance in the same cycle. Simultaneous drain and load: s2 takes the new data and stays valid.
- Latency and throughput:
  - A request accepted at edge t gives res_valid at edge t+2.
  - Sustains 1 result per cycle with res_ready held high.
- Backpressure:
  - res_ready low with s2 full: s2 holds all outputs stable.
  - If s1 is also full, s1 holds and req_ready goes all-zero.
  - No result may be dropped or duplicated.
- A requester not granted keeps its request pending. Every requester holding valid is granted within NREQ accepted handshakes.
- Reset mid-operation: in-flight s1/s2 contents are discarded and no result is emitted for them.

Test Plan:
- Single request, NREQ=4: req 2 with exp_a=130, exp_b=127, mant_a=0xC00000, mant_b=0x800000 -> after 2 cycles res_valid=1, res_id=2, res_exp=130, res_swap=0, res_mant_big=0xC00000, res_mant_small=0x100000, res_far=0.
- Swap and far cases:
  - exp_a=100, exp_b=140, mant_a=0xFFFFFF -> res_swap=1, res_exp=140, res_far=1, res_mant_small=0.
  - exp_a=exp_b=127 -> res_swap=0, align_exp_diff=0, res_mant_small=mant_b.
- Round robin: all four requesters hold valid continuously with res_ready=1 -> grant order 0,1,2,3,0,1. One result per cycle after 2-cycle fill. res_id sequence matches.
- Backpressure: stream 5 requests and drop res_ready for 3 cycles after the first result -> outputs held stable, req_ready all-zero once s1 and s2 are full, all 5 results delivered in order exactly once.
- Boundaries:
  - diff=23 -> res_far=0, res_mant_small = mant>>23.
  - diff=24 -> res_far=1, res_mant_small=0.
  - diff=255 (exp 255 vs 0) -> res_far=1, res_mant_small=0.
- Reset mid-stream: assert rst_n low with s1 and s2 full -> res_valid=0 immediately. After release, the next grant goes to requester 0 and no stale result appears.
